obi_rr_arbiter: RTL and testbench
=================================

Name: obi_rr_arbiter

Overview:
- Shares one OBI subordinate port (typically an on-chip memory or the simulation memory model) between NumMgr manager ports.
- Arbitrates A-channel requests round-robin and locks each arbitration decision until it is granted.
- Records the issuing manager of every accepted request in an in-order tracking FIFO and routes each R-channel response back to that manager.
- The downstream subordinate must answer in request order.

Parameters:
ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration shared by all ports; UseAtop and Integrity must be 0 (elaboration $error otherwise)
obi_req_t, logic, OBI request struct type (req, a, rready)
obi_rsp_t, logic, OBI response struct type (gnt, rvalid, r)
NumMgr, 4, number of manager ports; must be >= 2
MaxTrans, 4, maximum outstanding (granted, not yet responded) transactions; must be >= 1

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  reset; one clock; synchronous, active-low
mgr_req_i  input  NumMgr x obi_req_t  requests from managers
mgr_rsp_o  output  NumMgr x obi_rsp_t  responses to managers
sbr_req_o  output  obi_req_t  request to shared subordinate
sbr_rsp_i  input  obi_rsp_t  response from shared subordinate
busy_o  output  1  high while any transaction is outstanding

Behaviour:
- State:
  - rr_q: next-priority index, $clog2(NumMgr) bits.
  - lock_q, lock_idx_q: A-channel lock flag and locked manager index.
  - Tracking FIFO: MaxTrans entries of manager index, with cnt_q from 0..MaxTrans.
- Reset (rst_ni low at a clock edge):
  - rr_q=0, lock_q=0, FIFO flushed, cnt_q=0.
  - While rst_ni is low, combinationally force sbr_req_o.req=0, all mgr gnt=0, all mgr rvalid=0, busy_o=0.
- Selection:
  - If lock_q is set, sel=lock_idx_q.
  - Otherwise, sel is the first index i in the order rr_q, rr_q+1, ... (mod NumMgr) with mgr_req_i[i].req=1.
  - No requester: sel=rr_q, sbr req=0.
- Full: full = (cnt_q==MaxTrans).
- A channel (combinational, zero latency):
  - sbr_req_o.req = any_req && !full.
  - sbr_req_o.a = mgr_req_i[sel].a, passed unmodified (aid unchanged).
  - mgr_rsp_o[sel].gnt = sbr_rsp_i.gnt && !full. All other gnt=0.
- A handshake (sbr req && sbr gnt):
  - Push sel into the FIFO.
  - rr_q <= (sel+1) mod NumMgr.
  - lock_q <= 0.
- Lock:
  - If sbr req=1 and gnt=0, set lock_q <= 1 and lock_idx_q <= sel. This holds the choice, since OBI forbids the manager from changing a/req before gnt.
  - Lock persists through full stalls.
  - Lock is cleared only by a handshake or reset.
- R channel:
  - sbr_rsp_i.r is broadcast to all mgr_rsp_o[*].r.
  - mgr_rsp_o[head].rvalid = sbr_rsp_i.rvalid && cnt_q!=0. Others rvalid=0.
  - sbr_req_o.rready = mgr_req_i[head].rready if ObiCfg.UseRReady, else 1.
- R handshake (rvalid && rready && cnt_q!=0): pop FIFO.
- Count update:
  - Push and pop in the same cycle: cnt_q unchanged, FIFO pointers both advance.
  - Push only: cnt_q+1. Pop only: cnt_q-1.
  - Pointers wrap modulo MaxTrans.
- Full interplay:
  - While full, no push can occur.
  - A pop in the same cycle does not unblock gnt; gnt resumes the following cycle (no combinational pop->gnt path).
- Empty with rvalid:
  - Protocol violation. Response is dropped (no mgr rvalid).
  - Simulation assertion fires.
- busy_o = (cnt_q!=0).
- Assertions:
  - No FIFO overflow or underflow.
  - A locked manager must keep req=1 until gnt.
  - At most one mgr gnt high per cycle.

Test Plan:
- Single manager 2 writes then 1 read (NumMgr=4, MaxTrans=4, always-grant subordinate) -> each gnt same cycle as req; responses only on mgr 2, in order.
- Managers 0,1,3 request continuously -> grant order 0,1,3,0,1,3…; rr_q after grant of 3 equals 0.
- Subordinate holds gnt=0 for 3 cycles while mgr 1 requests; mgr 0 raises req in cycle 2 -> sbr addr stays mgr 1's value, mgr 1 granted first, mgr 0 next.
- Subordinate withholds rvalid; managers issue 5 requests with MaxTrans=4 -> 4 grants, 5th stalled (sbr req=0, busy_o=1) until one response pops; 5th granted the cycle after the pop.
- UseRReady=1, head manager holds rready=0 for 2 cycles -> rvalid stays on head manager, FIFO not popped, sbr rready=0; pops on the cycle rready=1.
- Assert rst_ni=0 for 1 cycle with 3 outstanding -> cnt_q=0, busy_o=0, rr_q=0; subsequent traffic starts at mgr 0 priority.

Source files
------------

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one in-order OBI subordinate among NumMgr managers.
// An in-order FIFO of manager indices routes each R-channel response back to its issuer.
package obi_pkg;

  typedef struct packed {
    logic UseRReady;
    logic UseAtop;
    logic Integrity;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b0, UseAtop: 1'b0, Integrity: 1'b0};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module obi_rr_arbiter #(
  parameter obi_pkg::obi_cfg_t ObiCfg   = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter int unsigned       NumMgr   = 4,
  parameter int unsigned       MaxTrans = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t mgr_req_i [NumMgr],
  output obi_rsp_t mgr_rsp_o [NumMgr],
  output obi_req_t sbr_req_o,
  input  obi_rsp_t sbr_rsp_i,
  output logic     busy_o
);

  localparam int unsigned IdxW = $clog2(NumMgr);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

  if (ObiCfg.UseAtop || ObiCfg.Integrity) begin : g_cfg_check
    $error("obi_rr_arbiter does not support UseAtop or Integrity");
  end
  if (NumMgr < 2) begin : g_mgr_check
    $error("obi_rr_arbiter needs NumMgr >= 2");
  end
  if (MaxTrans < 1) begin : g_trans_check
    $error("obi_rr_arbiter needs MaxTrans >= 1");
  end

  logic [IdxW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] fifo_q [MaxTrans];
  logic [IdxW-1:0] fifo_d [MaxTrans];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            any_req, found, full, sbr_req, gnt_ok, rvalid_ok, rready, push, pop;
  logic [IdxW-1:0] sel, head;
  logic [NumMgr-1:0] gnt_vec;
  int              idx;

  // Lock wins; otherwise search upward from rr_q for the first active request.
  always_comb begin
    any_req = 1'b0;
    found   = 1'b0;
    idx     = 0;
    sel     = rr_q;
    for (int i = 0; i < NumMgr; i++) begin
      any_req = any_req | mgr_req_i[i].req;
    end
    if (lock_q) begin
      sel = lock_idx_q;
    end else begin
      for (int i = 0; i < NumMgr; i++) begin
        idx = (int'(rr_q) + i) % NumMgr;
        if (!found && mgr_req_i[idx].req) begin
          found = 1'b1;
          sel   = IdxW'(idx);
        end
      end
    end
  end

  assign full      = (cnt_q == CntW'(MaxTrans));
  assign head      = fifo_q[rd_ptr_q];
  assign sbr_req   = rst_ni && any_req && !full;
  assign gnt_ok    = rst_ni && sbr_rsp_i.gnt && !full;
  assign rvalid_ok = rst_ni && sbr_rsp_i.rvalid && (cnt_q != '0);
  assign rready    = ObiCfg.UseRReady ? mgr_req_i[head].rready : 1'b1;
  assign push      = sbr_req && sbr_rsp_i.gnt;
  assign pop       = rvalid_ok && rready;
  assign busy_o    = rst_ni && (cnt_q != '0);

  always_comb begin
    sbr_req_o        = '0;
    sbr_req_o.req    = sbr_req;
    sbr_req_o.a      = mgr_req_i[sel].a;
    sbr_req_o.rready = rready;
    gnt_vec          = '0;
    for (int i = 0; i < NumMgr; i++) begin
      mgr_rsp_o[i]        = '0;
      mgr_rsp_o[i].r      = sbr_rsp_i.r;
      mgr_rsp_o[i].gnt    = gnt_ok && (sel == IdxW'(i));
      mgr_rsp_o[i].rvalid = rvalid_ok && (head == IdxW'(i));
      gnt_vec[i]          = mgr_rsp_o[i].gnt;
    end
  end

  // Full only looks at cnt_q, so a pop this cycle unblocks gnt next cycle.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (push) begin
      rr_d             = (sel == IdxW'(NumMgr - 1)) ? '0 : sel + IdxW'(1);
      lock_d           = 1'b0;
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = (wr_ptr_q == PtrW'(MaxTrans - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end else if (sbr_req) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(MaxTrans - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < MaxTrans; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
    end
  end

  // Protocol checks; a response arriving with nothing outstanding is dropped above.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt_q <= CntW'(MaxTrans)) && !(push && full));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(sbr_rsp_i.rvalid && (cnt_q == '0)));
  a_lock_holds_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> mgr_req_i[lock_idx_q].req);
  a_single_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_vec));

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter: 4 managers, 4 outstanding, rready honoured.
// Expected grant/response routing is hand-derived from the round-robin pointer history.
module tb_obi_rr_arbiter;

  localparam obi_pkg::obi_cfg_t TbCfg = '{UseRReady: 1'b1, UseAtop: 1'b0, Integrity: 1'b0};

  logic              clk = 1'b0;
  logic              rst_n;
  obi_pkg::obi_req_t mgr_req [4];
  obi_pkg::obi_rsp_t mgr_rsp [4];
  obi_pkg::obi_req_t sbr_req;
  obi_pkg::obi_rsp_t sbr_rsp;
  logic              busy;

  int check_count = 0;
  int fail_count  = 0;
  int order [6]   = '{3, 0, 1, 3, 0, 1};

  always #5 clk = ~clk;

  obi_rr_arbiter #(
    .ObiCfg   (TbCfg),
    .obi_req_t(obi_pkg::obi_req_t),
    .obi_rsp_t(obi_pkg::obi_rsp_t),
    .NumMgr   (4),
    .MaxTrans (4)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .mgr_req_i(mgr_req),
    .mgr_rsp_o(mgr_rsp),
    .sbr_req_o(sbr_req),
    .sbr_rsp_i(sbr_rsp),
    .busy_o   (busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic [31:0] addr, input logic we);
    mgr_req[m].req     = req;
    mgr_req[m].a.addr  = addr;
    mgr_req[m].a.we    = we;
    mgr_req[m].a.be    = 4'hF;
    mgr_req[m].a.wdata = addr ^ 32'h0000_FFFF;
    mgr_req[m].a.aid   = 4'(m);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [3:0] gnt_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mgr_rsp[i].gnt;
    return v;
  endfunction

  function automatic logic [3:0] rvalid_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mgr_rsp[i].rvalid;
    return v;
  endfunction

  function automatic logic [3:0] onehot(input int m);
    return 4'b0001 << m;
  endfunction

  initial begin
    for (int m = 0; m < 4; m++) begin
      mgr_req[m]        = '0;
      mgr_req[m].rready = 1'b1;
    end
    sbr_rsp = '0;
    rst_n   = 1'b0;
    tick();
    tick();

    // Outputs forced quiet while reset is low, even with live traffic
    applyStimulus(0, 1'b1, 32'h40, 1'b0);
    sbr_rsp.gnt    = 1'b1;
    sbr_rsp.rvalid = 1'b1;
    settle();
    checkOutput("rst_sbr_req", sbr_req.req, 1'b0);
    checkOutput("rst_gnt", gnt_vec(), 4'b0000);
    checkOutput("rst_rvalid", rvalid_vec(), 4'b0000);
    checkOutput("rst_busy", busy, 1'b0);
    tick();
    checkOutput("rst_cnt", dut.cnt_q, 0);
    checkOutput("rst_rr", dut.rr_q, 0);
    applyStimulus(0, 1'b0, 32'h0, 1'b0);
    sbr_rsp.rvalid = 1'b0;
    rst_n          = 1'b1;
    tick();

    // Single manager 2: two writes then a read, always-grant subordinate
    applyStimulus(2, 1'b1, 32'h100, 1'b1);
    settle();
    checkOutput("t1_sbr_req", sbr_req.req, 1'b1);
    checkOutput("t1_addr0", sbr_req.a.addr, 32'h100);
    checkOutput("t1_aid", sbr_req.a.aid, 4'd2);
    checkOutput("t1_gnt0", gnt_vec(), 4'b0100);
    tick();
    checkOutput("t1_busy", busy, 1'b1);
    checkOutput("t1_cnt1", dut.cnt_q, 1);
    applyStimulus(2, 1'b1, 32'h104, 1'b1);
    settle();
    checkOutput("t1_gnt1", gnt_vec(), 4'b0100);
    tick();
    applyStimulus(2, 1'b1, 32'h108, 1'b0);
    sbr_rsp.rvalid  = 1'b1;
    sbr_rsp.r.rdata = 32'hA0;
    settle();
    checkOutput("t1_gnt2", gnt_vec(), 4'b0100);
    checkOutput("t1_rvalid0", rvalid_vec(), 4'b0100);
    checkOutput("t1_rdata0", mgr_rsp[2].r.rdata, 32'hA0);
    tick();
    checkOutput("t1_cnt_pushpop", dut.cnt_q, 2);
    applyStimulus(2, 1'b0, 32'h0, 1'b0);
    sbr_rsp.r.rdata = 32'hA1;
    settle();
    checkOutput("t1_rvalid1", rvalid_vec(), 4'b0100);
    checkOutput("t1_rdata1", mgr_rsp[2].r.rdata, 32'hA1);
    tick();
    sbr_rsp.r.rdata = 32'hA2;
    settle();
    checkOutput("t1_rvalid2", rvalid_vec(), 4'b0100);
    tick();
    sbr_rsp.rvalid = 1'b0;
    checkOutput("t1_cnt_end", dut.cnt_q, 0);
    checkOutput("t1_busy_end", busy, 1'b0);

    // Managers 0,1,3 continuous; rr_q starts at 3 after the mgr 2 traffic
    applyStimulus(0, 1'b1, 32'h10, 1'b0);
    applyStimulus(1, 1'b1, 32'h11, 1'b0);
    applyStimulus(3, 1'b1, 32'h13, 1'b0);
    for (int k = 0; k < 6; k++) begin
      sbr_rsp.rvalid = (k > 0);
      settle();
      checkOutput($sformatf("t2_gnt%0d", k), gnt_vec(), onehot(order[k]));
      if (k > 0) checkOutput($sformatf("t2_rvalid%0d", k), rvalid_vec(), onehot(order[k-1]));
      tick();
      if (order[k] == 3) checkOutput($sformatf("t2_rr%0d", k), dut.rr_q, 0);
    end
    applyStimulus(0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0);
    applyStimulus(3, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("t2_rvalid_last", rvalid_vec(), onehot(1));
    tick();
    sbr_rsp.rvalid = 1'b0;
    checkOutput("t2_cnt_end", dut.cnt_q, 0);

    // Lock: gnt withheld 3 cycles on mgr 1, mgr 0 joins in cycle 2 (rr_q=2)
    sbr_rsp.gnt = 1'b0;
    applyStimulus(1, 1'b1, 32'h200, 1'b1);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) applyStimulus(0, 1'b1, 32'h300, 1'b0);
      settle();
      checkOutput($sformatf("t3_addr_c%0d", c), sbr_req.a.addr, 32'h200);
      checkOutput($sformatf("t3_nognt_c%0d", c), gnt_vec(), 4'b0000);
      tick();
      if (c == 0) checkOutput("t3_lock", dut.lock_q, 1'b1);
    end
    sbr_rsp.gnt = 1'b1;
    settle();
    checkOutput("t3_addr_gnt", sbr_req.a.addr, 32'h200);
    checkOutput("t3_gnt_m1", gnt_vec(), 4'b0010);
    tick();
    applyStimulus(1, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("t3_gnt_m0", gnt_vec(), 4'b0001);
    checkOutput("t3_addr_m0", sbr_req.a.addr, 32'h300);
    tick();
    applyStimulus(0, 1'b0, 32'h0, 1'b0);
    checkOutput("t3_rr", dut.rr_q, 1);
    sbr_rsp.rvalid = 1'b1;
    settle();
    checkOutput("t3_rvalid_m1", rvalid_vec(), 4'b0010);
    tick();
    checkOutput("t3_rvalid_m0", rvalid_vec(), 4'b0001);
    tick();
    sbr_rsp.rvalid = 1'b0;
    checkOutput("t3_cnt_end", dut.cnt_q, 0);

    // Full stall: five requests from mgr 2 with responses withheld
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2, 1'b1, 32'h400 + 32'(4 * k), 1'b1);
      settle();
      checkOutput($sformatf("t4_gnt%0d", k), gnt_vec(), 4'b0100);
      tick();
    end
    checkOutput("t4_cnt_full", dut.cnt_q, 4);
    applyStimulus(2, 1'b1, 32'h410, 1'b1);
    for (int c = 0; c < 2; c++) begin
      settle();
      checkOutput($sformatf("t4_stall_req%0d", c), sbr_req.req, 1'b0);
      checkOutput($sformatf("t4_stall_gnt%0d", c), gnt_vec(), 4'b0000);
      checkOutput($sformatf("t4_stall_busy%0d", c), busy, 1'b1);
      tick();
    end
    sbr_rsp.rvalid = 1'b1;
    settle();
    checkOutput("t4_pop_nognt", gnt_vec(), 4'b0000);
    checkOutput("t4_pop_rvalid", rvalid_vec(), 4'b0100);
    tick();
    checkOutput("t4_cnt_after_pop", dut.cnt_q, 3);
    sbr_rsp.rvalid = 1'b0;
    settle();
    checkOutput("t4_gnt_resume", gnt_vec(), 4'b0100);
    checkOutput("t4_req_resume", sbr_req.req, 1'b1);
    tick();
    checkOutput("t4_cnt_refull", dut.cnt_q, 4);
    applyStimulus(2, 1'b0, 32'h0, 1'b0);
    sbr_rsp.rvalid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    sbr_rsp.rvalid = 1'b0;
    checkOutput("t4_cnt_end", dut.cnt_q, 0);

    // rready backpressure from head manager 3 (rr_q=3)
    applyStimulus(3, 1'b1, 32'h500, 1'b0);
    settle();
    checkOutput("t5_gnt", gnt_vec(), 4'b1000);
    tick();
    applyStimulus(3, 1'b0, 32'h0, 1'b0);
    mgr_req[3].rready = 1'b0;
    sbr_rsp.rvalid    = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      checkOutput($sformatf("t5_rvalid%0d", c), rvalid_vec(), 4'b1000);
      checkOutput($sformatf("t5_rready%0d", c), sbr_req.rready, 1'b0);
      tick();
      checkOutput($sformatf("t5_cnt_hold%0d", c), dut.cnt_q, 1);
    end
    mgr_req[3].rready = 1'b1;
    settle();
    checkOutput("t5_rready_on", sbr_req.rready, 1'b1);
    tick();
    sbr_rsp.rvalid = 1'b0;
    checkOutput("t5_cnt_end", dut.cnt_q, 0);

    // Reset with three outstanding from mgr 1
    applyStimulus(1, 1'b1, 32'h600, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    checkOutput("t6_cnt3", dut.cnt_q, 3);
    checkOutput("t6_busy", busy, 1'b1);
    rst_n = 1'b0;
    settle();
    checkOutput("t6_rst_req", sbr_req.req, 1'b0);
    checkOutput("t6_rst_gnt", gnt_vec(), 4'b0000);
    checkOutput("t6_rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    checkOutput("t6_cnt0", dut.cnt_q, 0);
    checkOutput("t6_rr0", dut.rr_q, 0);
    checkOutput("t6_lock0", dut.lock_q, 1'b0);
    for (int m = 0; m < 4; m++) applyStimulus(m, 1'b1, 32'h700 + 32'(m), 1'b0);
    settle();
    checkOutput("t6_gnt_m0", gnt_vec(), 4'b0001);
    tick();
    settle();
    checkOutput("t6_gnt_m1", gnt_vec(), 4'b0010);
    tick();
    for (int m = 0; m < 4; m++) applyStimulus(m, 1'b0, 32'h0, 1'b0);
    sbr_rsp.rvalid = 1'b1;
    settle();
    checkOutput("t6_rvalid_m0", rvalid_vec(), 4'b0001);
    tick();
    checkOutput("t6_rvalid_m1", rvalid_vec(), 4'b0010);
    tick();
    sbr_rsp.rvalid = 1'b0;
    checkOutput("t6_cnt_end", dut.cnt_q, 0);
    checkOutput("t6_busy_end", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
